// File: rtl/seq_alu.sv
// seq_alu: RV32I base ALU plus iterative RV32M multiply/divide behind valid/ready handshakes.
// Latency: 1 cycle for base, reserved and divide special-case ops; XLEN+1 cycles for multiply/divide.
// Backpressure: a finished result is held in DONE until out_ready; in_ready stays low while busy, killed or in reset.
module seq_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alusel,
  input  logic [XLEN-1:0] input_a,
  input  logic [XLEN-1:0] input_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] aluout
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0]   LAST    = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BASE, S_ITER, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [4:0]        r_op;
  logic [XLEN-1:0]   r_a, r_b, r_mag, r_out;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg_lo, r_neg_hi;
  logic [CW-1:0]     r_cnt;

  logic              w_accept, w_is_mul, w_is_div, w_div_special, w_go_iter;
  logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_abs, w_b_abs, w_base_res, w_iter_res, w_quo, w_rem;
  logic [SW-1:0]     w_shamt;
  logic [XLEN:0]     w_mul_sum, w_div_trial;
  logic [2*XLEN-1:0] w_mul_step, w_div_step, w_prod;

  // Kill also masks in_ready so the upstream stage never sees a handshake that is being dropped.
  assign in_ready  = !rst && !kill && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign aluout    = r_out;

  // Operand decode at accept: signedness per M op, magnitudes, and divide special cases.
  assign w_is_mul = (alusel[4:2] == 3'b100);
  assign w_is_div = (alusel[4:2] == 3'b101);
  // MUL/MULH/MULHSU treat A as signed; MUL/MULH treat B as signed; DIV/REM (bit0 clear) are signed.
  assign w_a_sgn  = w_is_mul ? (alusel[1:0] != 2'b11) : !alusel[0];
  assign w_b_sgn  = w_is_mul ? !alusel[1] : !alusel[0];
  assign w_a_neg  = w_a_sgn && input_a[XLEN-1];
  assign w_b_neg  = w_b_sgn && input_b[XLEN-1];
  assign w_a_abs  = w_a_neg ? -input_a : input_a;
  assign w_b_abs  = w_b_neg ? -input_b : input_b;
  assign w_div_special = w_is_div && ((input_b == '0) ||
                         (!alusel[0] && (input_a == MIN_NEG) && (&input_b)));
  assign w_go_iter = w_is_mul || (w_is_div && !w_div_special);

  // One radix-2 step: multiplier lives in acc low half and drains out as the product shifts in.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_mag : '0)};
  assign w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};
  // One restoring step: remainder in acc high half, dividend shifts out of the low half as quotient bits enter.
  assign w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_mag};
  assign w_div_step  = w_div_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                         : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  // Sign correction of the finished magnitudes.
  assign w_prod = r_neg_lo ? -r_acc : r_acc;
  assign w_quo  = r_neg_lo ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_hi ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_iter_res = (r_op[2:0] == 3'b000) ? w_prod[XLEN-1:0] :
                      (r_op[2] == 1'b0)     ? w_prod[2*XLEN-1:XLEN] :
                      (r_op[1] == 1'b0)     ? w_quo : w_rem;

  assign w_shamt = r_b[SW-1:0];

  // Single-cycle result from latched operands: base ops, reserved codes and divide special cases.
  always_comb begin
    w_base_res = '0;
    case (r_op)
      5'h00: w_base_res = r_a + r_b;
      5'h01: w_base_res = r_a - r_b;
      5'h02: w_base_res = r_a & r_b;
      5'h03: w_base_res = r_a | r_b;
      5'h04: w_base_res = r_a ^ r_b;
      5'h05: w_base_res = r_a >> w_shamt;
      5'h06: w_base_res = $signed(r_a) >>> w_shamt;
      5'h07: w_base_res = r_a << w_shamt;
      5'h08: w_base_res = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      5'h09: w_base_res = {{(XLEN-1){1'b0}}, (r_a < r_b)};
      5'h0E: w_base_res = r_b;
      5'h0F: w_base_res = r_a;
      // Only special cases reach here: B==0 gives all ones, signed overflow gives A.
      5'h14, 5'h15: w_base_res = (r_b == '0) ? '1 : r_a;
      // B==0 gives A, signed overflow gives 0.
      5'h16, 5'h17: w_base_res = (r_b == '0) ? r_a : '0;
      default: w_base_res = '0;
    endcase
  end

  // Next-state: kill overrides everything, DONE may chain straight into the next op.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_go_iter ? S_ITER : S_BASE;
      S_BASE: w_next = S_DONE;
      S_ITER: if (r_cnt == LAST) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = w_accept ? (w_go_iter ? S_ITER : S_BASE) : S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (kill) w_next = S_IDLE;
  end

  // State, operand latches, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mag    <= '0;
      r_acc    <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_cnt    <= '0;
      r_out    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op  <= alusel;
        r_a   <= input_a;
        r_b   <= input_b;
        r_cnt <= '0;
        if (w_is_mul) begin
          r_mag    <= w_a_abs;
          r_acc    <= {{XLEN{1'b0}}, w_b_abs};
          r_neg_lo <= w_a_neg ^ w_b_neg;
          r_neg_hi <= w_a_neg ^ w_b_neg;
        end else begin
          r_mag    <= w_b_abs;
          r_acc    <= {{XLEN{1'b0}}, w_a_abs};
          r_neg_lo <= w_a_neg ^ w_b_neg;
          r_neg_hi <= w_a_neg;
        end
      end else if ((r_state == S_ITER) && !kill) begin
        // XLEN iteration cycles, then one cycle to sign-correct into the result register.
        if (r_cnt != LAST) begin
          r_acc <= r_op[2] ? w_div_step : w_mul_step;
          r_cnt <= r_cnt + CW'(1);
        end else begin
          r_out <= w_iter_res;
        end
      end else if ((r_state == S_BASE) && !kill) begin
        r_out <= w_base_res;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed vectors, decoupled driver and monitor.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, kill, out_valid, out_ready;
  logic [4:0]  alusel;
  logic [31:0] input_a, input_b, aluout;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, kill16;
  logic [4:0]  alusel16;
  logic [15:0] input_a16, input_b16, aluout16;

  always #5 clk = ~clk;

  seq_alu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alusel(alusel),
    .input_a(input_a), .input_b(input_b), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .aluout(aluout));

  seq_alu #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .alusel(alusel16),
    .input_a(input_a16), .input_b(input_b16), .kill(kill16), .out_valid(out_valid16),
    .out_ready(out_ready16), .aluout(aluout16));

  typedef struct {
    logic [31:0] val;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   seen   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: latency on first sight of a result, value on handshake, accept times recorded.
  always @(negedge clk) begin
    if (rst || kill) begin
      acc_q.delete();
      seen = 1'b0;
    end else begin
      if (!out_valid) seen = 1'b0;
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got out_valid with %h, expected no result", aluout);
        end else begin
          chk("latency", 32'(cyc - acc_q[0]), 32'(exp_q[0].lat));
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0 && acc_q.size() > 0) begin
        chk("result", aluout, exp_q[0].val);
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        seen = 1'b0;
      end
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ev, input int lat, input bit track);
    bit ok = 1'b0;
    exp_t e;
    e.val = ev;
    e.lat = lat;
    if (track) exp_q.push_back(e);
    @(posedge clk); #1;
    alusel = op; input_a = a; input_b = b; in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready was 0, expected 1 within 200 cycles");
      if (track) void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  localparam int NV = 28;
  logic [4:0]  v_op  [NV] = '{5'h00, 5'h06, 5'h09, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05,
                              5'h07, 5'h08, 5'h0E, 5'h0F, 5'h0B, 5'h11, 5'h13, 5'h10,
                              5'h12, 5'h14, 5'h16, 5'h15, 5'h17, 5'h14, 5'h16, 5'h15,
                              5'h17, 5'h14, 5'h16, 5'h1A};
  logic [31:0] v_a   [NV] = '{32'h7FFFFFFF, 32'h80000000, 32'h1, 32'h5, 32'hF0F0F0F0, 32'hF0F0F0F0,
                              32'hFFFF0000, 32'h80000000, 32'h1, 32'hFFFFFFFF, 32'h1234, 32'h1234,
                              32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFF9, 32'hFFFFFFF9, 32'h7, 32'h7, 32'h80000000, 32'h80000000,
                              32'h64, 32'h64, 32'h7, 32'h7, 32'h5};
  logic [31:0] v_b   [NV] = '{32'h1, 32'h4, 32'hFFFFFFFF, 32'h7, 32'hFF00FF00, 32'h0F0F0000,
                              32'h0F0F0F0F, 32'h24, 32'h1F, 32'h1, 32'h5678, 32'h5678, 32'h5,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2, 32'h2,
                              32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7, 32'h7,
                              32'hFFFFFFFE, 32'hFFFFFFFE, 32'h5};
  logic [31:0] v_exp [NV] = '{32'h80000000, 32'hF8000000, 32'h1, 32'hFFFFFFFE, 32'hF000F000,
                              32'hFFFFF0F0, 32'hF0F00F0F, 32'h08000000, 32'h80000000, 32'h1,
                              32'h5678, 32'h1234, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFF,
                              32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7, 32'h80000000, 32'h0,
                              32'hE, 32'h2, 32'hFFFFFFFD, 32'h1, 32'h0};
  int          v_lat [NV] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 33, 33, 33, 33, 33, 33,
                              1, 1, 1, 1, 33, 33, 33, 33, 1};

  initial begin
    int n;
    int t0;
    bit ok;
    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
    alusel = '0; input_a = '0; input_b = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; kill16 = 1'b0;
    alusel16 = '0; input_a16 = '0; input_b16 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_aluout", aluout, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
    chk("rst_out_valid16", {31'b0, out_valid16}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {31'b0, in_ready}, 32'h1);

    // Directed vectors, issued back to back through the scoreboard
    for (int i = 0; i < NV; i++) issue(v_op[i], v_a[i], v_b[i], v_exp[i], v_lat[i], 1'b1);
    drain();

    // Backpressure: MUL result held for 5 cycles with a competing request offered
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(5'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 33, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = out_valid;
    end
    chk("bp_out_valid_seen", {31'b0, ok}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b1; alusel = 5'h00; input_a = 32'h3; input_b = 32'h4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_aluout_stable", aluout, 32'h1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // Kill at iteration 10 of a DIV with a competing request in the same cycle
    issue(5'h14, 32'h64, 32'h7, 32'h0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    kill = 1'b1; in_valid = 1'b1; alusel = 5'h00; input_a = 32'h1; input_b = 32'h1;
    @(negedge clk);
    chk("kill_in_ready", {31'b0, in_ready}, 32'h0);
    chk("kill_out_valid", {31'b0, out_valid}, 32'h0);
    @(posedge clk); #1;
    kill = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("kill_idle_out_valid", {31'b0, out_valid}, 32'h0);
    chk("kill_idle_in_ready", {31'b0, in_ready}, 32'h1);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("kill_no_result", 32'(n), 32'h0);

    // Reset pulse in the middle of an iterative op
    issue(5'h13, 32'hFFFFFFFF, 32'h2, 32'h0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_aluout", aluout, 32'h0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'h1);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("midrst_no_result", 32'(n), 32'h0);

    // XLEN = 16 instance: MULHU 0xFFFF x 0xFFFF
    @(posedge clk); #1;
    alusel16 = 5'h13; input_a16 = 16'hFFFF; input_b16 = 16'hFFFF; in_valid16 = 1'b1;
    ok = 1'b0;
    t0 = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready16;
    end
    t0 = cyc + 1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = out_valid16;
    end
    chk("x16_out_valid_seen", {31'b0, ok}, 32'h1);
    chk("x16_latency", 32'(cyc - t0), 32'd17);
    chk("x16_mulhu", {16'h0, aluout16}, 32'h0000FFFE);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
